// File: rtl/vga_frame_reader.sv
// Read side of the video frame buffer. It scans 8x8-pixel cells in raster order and drives VGA timing.
// Outputs are registered two clocks after each pixel tick, so sync, active and colour stay aligned.
module vga_frame_reader #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int COLS    = 80
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_ce,
    output logic        o_we,
    output logic [12:0] o_addr,
    input  logic [15:0] i_data,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [3:0]  o_red,
    output logic [3:0]  o_green,
    output logic [3:0]  o_blue,
    output logic        o_active,
    output logic        o_frame_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = $clog2(CLK_DIV);

    typedef struct packed {
        logic vld;
        logic vis;
        logic rd;
        logic hs;
        logic vs;
        logic fs;
    } stage_t;

    logic          run, tick, visible, rd;
    logic [DW-1:0] div;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [12:0]   row, col, cell_addr;
    stage_t        s1;
    logic [11:0]   colour_q, colour;
    logic          unused_hi;

    assign run       = i_enable && !i_rst;
    assign tick      = run && (div == DW'(CLK_DIV - 1));
    assign visible   = (h < HW'(H_VIS)) && (v < VW'(V_VIS));
    assign rd        = tick && visible && (h[2:0] == 3'd0);
    assign row       = 13'(v >> 3);
    assign col       = 13'(h >> 3);
    assign cell_addr = row * 13'(COLS) + col;

    assign o_ce      = rd;
    assign o_addr    = rd ? cell_addr : 13'd0;
    assign o_we      = 1'b0;

    // Bits [15:12] of a cell carry no colour.
    assign unused_hi = ^i_data[15:12];

    always_ff @(posedge i_clk) begin
        if (!run) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (tick) begin
            div <= '0;
            if (h == HW'(H_TOT - 1)) begin
                h <= '0;
                v <= (v == VW'(V_TOT - 1)) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // Stage 1 carries the pixel attributes while the memory read is in flight.
    always_ff @(posedge i_clk) begin
        if (!run) begin
            s1 <= '0;
        end else begin
            s1.vld <= tick;
            s1.vis <= visible;
            s1.rd  <= rd;
            s1.hs  <= !((h >= HW'(H_VIS + H_FP)) && (h < HW'(H_VIS + H_FP + H_SYNC)));
            s1.vs  <= !((v >= VW'(V_VIS + V_FP)) && (v < VW'(V_VIS + V_FP + V_SYNC)));
            s1.fs  <= (h == '0) && (v == '0);
        end
    end

    // The first pixel of a cell takes the fresh read data; the other seven pixels reuse the latch.
    assign colour = s1.rd ? i_data[11:0] : colour_q;

    always_ff @(posedge i_clk) begin
        if (!run) begin
            colour_q      <= '0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_active      <= 1'b0;
            o_frame_start <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_frame_start <= 1'b0;
            if (s1.vld) begin
                if (s1.rd)
                    colour_q <= i_data[11:0];
                o_hsync       <= s1.hs;
                o_vsync       <= s1.vs;
                o_active      <= s1.vis;
                o_frame_start <= s1.fs;
                {o_red, o_green, o_blue} <= s1.vis ? colour : 12'd0;
            end
        end
    end
endmodule
